echo_mixer: RTL
===============

Name: echo_mixer

Overview:
- Upstream and downstream partner of the SRAM delay-line controller.
- Accepts one stereo sample per audio frame and fires the controller's single-cycle rw_trigger.
- Picks up the delayed sample the controller reads back on sram_data.
- Produces two outputs:
  - the mixed output sample (dry + attenuated delayed);
  - the feedback word the controller writes back into the delay line on write_data.

Parameters:
- FB_SHIFT, 1: arithmetic right shift applied to the delayed sample before adding it into the feedback word. Gain is 2^-FB_SHIFT.
- WET_SHIFT, 1: arithmetic right shift applied to the delayed sample before adding it into sample_out.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset. One clock; reset is synchronous and active-low.
- sample_valid  in  1  one-cycle strobe, sample_in valid
- sample_in  in  32  [31:16] left, [15:0] right; each a 16-bit two's complement value
- sram_data  in  32  delayed sample from the controller, same packing
- rw_trigger  out  1  one-cycle pulse that starts a controller transaction
- write_data  out  32  feedback word to the controller, same packing
- sample_out  out  32  mixed output sample, registered
- out_valid  out  1  one-cycle strobe, sample_out updated
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky flag: a sample was dropped

Behaviour:
- All regs update on posedge clk.
- Reset: n_rst==0 at an edge puts the following values after that edge, regardless of state:
  - state = IDLE, cnt = 0;
  - rw_trigger = 0, out_valid = 0, busy = 0, overrun = 0;
  - sample_out = 0, write_data = 0, captured dry sample = 0.
- Let A be the edge at which sample_valid is sampled high in IDLE.
  - At A, sample_in is captured into dry.
- States and cycle timing, counted from A:
  - IDLE: on sample_valid go to TRIG.
  - TRIG (cycle A+1): rw_trigger = 1, the only cycle it is high. Then go to WAIT_RD with cnt = 0.
  - WAIT_RD (A+2..A+5): cnt increments each cycle; at cnt == 3 go to MIX. sram_data is don't-care in this window.
  - MIX (A+6): sram_data holds the full delayed sample.
    - At the end of this cycle: sample_out <= mix(dry, sram_data, WET_SHIFT) and out_valid <= 1.
    - Then go to WAIT_WR with cnt = 0.
  - WAIT_WR (A+7..A+8): out_valid is high during A+7 only. At cnt == 1 go to IDLE.
  - IDLE is reached at A+9. sample_valid in that cycle is accepted with the same timing.
- write_data:
  - Equals mix(dry, sram_data, FB_SHIFT) combinationally during MIX and WAIT_WR (A+6..A+8). This covers the controller's low-half write at A+6 and high-half write at A+8.
  - Is 32'h0 in every other state.
- mix(d, s, k), computed per channel independently:
  - 17-bit signed sum d + (s >>> k), with the shift sign-extending;
  - saturate to [16'h8000, 16'h7FFF]. No wrap-around, ever.
- busy is combinational: busy = (state != IDLE).
- Overrun:
  - sample_valid while busy: the sample is dropped, dry is unchanged, the in-flight transaction is unaffected, overrun <= 1.
  - overrun clears only on reset.
- sample_out holds its last value between transactions.
- Reset mid-transaction: abort immediately, with no further trigger or out_valid. The controller reset is asserted in the same domain.
- No back-pressure on the output side.

Decomposition:
- Package echo_pkg holds:
  - the state enum typedef (IDLE, TRIG, WAIT_RD, MIX, WAIT_WR);
  - localparams RD_WAIT_CYCLES = 4 and WR_WAIT_CYCLES = 2;
  - function sat16(17-bit signed) returning 16 bits;
  - the channel index constants L_HI = 31, L_LO = 16, R_HI = 15, R_LO = 0.
- Sub-module echo_channel_mix: combinational 16-bit dry + shifted-wet saturating adder, parameterised by SHIFT.
  - Four instances: {left, right} × {out, feedback}.

Test Plan (FB_SHIFT = WET_SHIFT = 1; controller model returns the given sram_data from A+6):
- Reset:
  - Stimulus: n_rst low for 2 cycles mid-stream.
  - Required: every output is 0 and busy = 0 after the first low edge.
- Empty delay line:
  - Stimulus: sample_in 0x1000F000, sram_data 0.
  - Required: rw_trigger high only at A+1; out_valid at A+7 with sample_out = 0x1000F000; write_data = 0x1000F000 during A+6..A+8 and 0 elsewhere.
- Mix:
  - Stimulus: dry 0x10000100, sram_data 0x2000E000.
  - Required: sample_out = 0x2000F100 and write_data = 0x2000F100.
- Saturation:
  - Stimulus: dry 0x70009000, sram_data 0x7FFF8000.
  - Required: sample_out = 0x7FFF8000 (left clips positive, right clips negative).
- Overrun:
  - Stimulus: second sample_valid at A+3.
  - Required: dropped, overrun = 1 from A+4, second rw_trigger absent.
  - Stimulus: sample_valid at A+9.
  - Required: accepted, rw_trigger at A+10, overrun stays 1.
- Reset mid-transaction:
  - Stimulus: n_rst low at A+4.
  - Required: IDLE next cycle, write_data = 0, no out_valid; a new sample afterwards runs with normal A-relative timing.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types, timing constants and saturation helper for the echo mixer.
package echo_pkg;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RD, MIX, WAIT_WR} echo_state_t;

  localparam int RD_WAIT_CYCLES = 4;
  localparam int WR_WAIT_CYCLES = 2;

  localparam int L_HI = 31;
  localparam int L_LO = 16;
  localparam int R_HI = 15;
  localparam int R_LO = 0;

  // Clamp a 17-bit signed sum into the 16-bit two's complement range.
  function automatic logic [15:0] sat16(input logic signed [16:0] s);
    if (s[16] != s[15]) return s[16] ? 16'h8000 : 16'h7FFF;
    return s[15:0];
  endfunction

endpackage

// File: rtl/echo_channel_mix.sv
// One channel of dry + (wet >>> SHIFT), saturated to 16 bits.
module echo_channel_mix
  import echo_pkg::*;
#(
  parameter int SHIFT = 1
) (
  input  logic [15:0] dry,
  input  logic [15:0] wet,
  output logic [15:0] mix
);

  logic signed [15:0] wet_sh;
  logic signed [16:0] sum;

  assign wet_sh = $signed(wet) >>> SHIFT;
  assign sum    = {dry[15], dry} + {wet_sh[15], wet_sh};
  assign mix    = sat16(sum);

endmodule

// File: rtl/echo_mixer.sv
// Frame sequencer for the SRAM delay line: triggers a read/write transaction,
// mixes the delayed sample into the output and builds the feedback word.
module echo_mixer
  import echo_pkg::*;
#(
  parameter int FB_SHIFT  = 1,
  parameter int WET_SHIFT = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sample_valid,
  input  logic [31:0] sample_in,
  input  logic [31:0] sram_data,
  output logic        rw_trigger,
  output logic [31:0] write_data,
  output logic [31:0] sample_out,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
);

  echo_state_t state;
  logic [1:0]  cnt;
  logic [31:0] dry;
  logic [31:0] mix_out;
  logic [31:0] mix_fb;

  echo_channel_mix #(.SHIFT(WET_SHIFT)) u_out_l (
    .dry(dry[L_HI:L_LO]), .wet(sram_data[L_HI:L_LO]), .mix(mix_out[L_HI:L_LO]));
  echo_channel_mix #(.SHIFT(WET_SHIFT)) u_out_r (
    .dry(dry[R_HI:R_LO]), .wet(sram_data[R_HI:R_LO]), .mix(mix_out[R_HI:R_LO]));
  echo_channel_mix #(.SHIFT(FB_SHIFT)) u_fb_l (
    .dry(dry[L_HI:L_LO]), .wet(sram_data[L_HI:L_LO]), .mix(mix_fb[L_HI:L_LO]));
  echo_channel_mix #(.SHIFT(FB_SHIFT)) u_fb_r (
    .dry(dry[R_HI:R_LO]), .wet(sram_data[R_HI:R_LO]), .mix(mix_fb[R_HI:R_LO]));

  assign busy       = (state != IDLE);
  assign rw_trigger = (state == TRIG);
  // Feedback stays valid across both controller write slots (low half in MIX, high half late in WAIT_WR).
  assign write_data = (state == MIX || state == WAIT_WR) ? mix_fb : 32'h0;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      sample_out <= '0;
      dry        <= '0;
    end else begin
      out_valid <= 1'b0;
      if (sample_valid && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_valid) begin
          dry   <= sample_in;
          state <= TRIG;
        end
        TRIG: begin
          cnt   <= '0;
          state <= WAIT_RD;
        end
        WAIT_RD: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'(RD_WAIT_CYCLES - 1)) state <= MIX;
        end
        MIX: begin
          sample_out <= mix_out;
          out_valid  <= 1'b1;
          cnt        <= '0;
          state      <= WAIT_WR;
        end
        WAIT_WR: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'(WR_WAIT_CYCLES - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
